// File: rtl/mem_pkg.sv
// Shared types and default widths for the CPU/RAM memory arbiter.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 16;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic {
    SEL_IF,
    SEL_D
  } sel_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// Build option MEM_ARB_RR_EN: round-robin on contention; otherwise D beats IF.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  sel_e last_win,
  output sel_e sel
);

  always_comb begin
    sel = SEL_D;
    if (if_req && !d_req) begin
      sel = SEL_IF;
    end
`ifdef MEM_ARB_RR_EN
    else if (if_req && d_req) begin
      // On contention the port that did not win last time goes first.
      sel = (last_win == SEL_D) ? SEL_IF : SEL_D;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_win;
  assign unused_last_win = last_win;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port synchronous RAM.
// Build option MEM_ARB_RR_EN adds a last-winner pointer for round-robin arbitration.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state_q, state_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  sel_e              pick_sel;
  sel_e              last_win;

`ifdef MEM_ARB_RR_EN
  sel_e last_q, last_d;
  assign last_win = last_q;
`else
  assign last_win = SEL_IF;
`endif

  mem_arb_pick u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .last_win(last_win),
    .sel     (pick_sel)
  );

  always_comb begin
    state_d     = state_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif
    if (state_q == IDLE) begin
      if (if_req || d_req) begin
        state_d = ACCESS;
`ifdef MEM_ARB_RR_EN
        last_d  = pick_sel;
`endif
        if (pick_sel == SEL_D) begin
          d_gnt_d     = 1'b1;
          ram_addr_d  = d_addr;
          ram_we_d    = d_we;
          ram_wdata_d = d_wdata;
        end else begin
          if_gnt_d   = 1'b1;
          ram_addr_d = if_addr;
        end
      end
    end else begin
      // The RAM returns read data one cycle after the access cycle.
      state_d     = IDLE;
      if_rvalid_d = if_gnt_q;
      d_rvalid_d  = d_gnt_q && !ram_we_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= SEL_IF;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = ram_rdata;
  assign d_rdata   = ram_rdata;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule
